text_msg_arbiter: RTL and testbench
===================================

Name: text_msg_arbiter

Overview:
- Shares the single LCD text-scroller input (ascii_data / ascii_data_ready) among NUM_REQ message sources, e.g. caller ID, menu, call status and error text.
- Each source streams a message byte-by-byte under a valid/ready handshake.
- The block buffers the whole message, then replays it as one contiguous burst with ascii_data_ready held high, which is the framing the scroller requires.
- Enforces a minimum display time before a lower- or equal-priority source may replace the current text.

Parameters:
- NUM_REQ, 4, number of requesters; index 0 has the highest priority.
- MAX_LEN, 64, buffer depth in characters; range 16..2048.
- MIN_HOLD_CNT, 27000000, cycles a sent message is protected from same- or lower-priority replacement; must be > GAP_CYCLES.
- GAP_CYCLES, 2, minimum cycles with ascii_data_ready low between bursts.
- COLLECT_TIMEOUT, 1000000, maximum idle cycles between bytes of one message before it is aborted.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester byte valid.
- req_data  in  8*NUM_REQ  per-requester byte; requester i uses bits [8i+7:8i].
- req_last  in  NUM_REQ  marks the final byte of a message.
- req_ready  out  NUM_REQ  per-requester byte accept.
- ascii_data  out  8  character to the scroller.
- ascii_data_ready  out  1  message framing strobe to the scroller.
- owner  out  clog2(NUM_REQ)  index of the source of the current or most recent text.
- owner_valid  out  1  owner field is meaningful.
- busy  out  1  high in COLLECT or SEND.

Behaviour:
- Reset (any state, takes effect next edge):
  - state=IDLE; req_ready=0; ascii_data_ready=0; ascii_data=8'h20.
  - owner=0; owner_valid=0; busy=0; all counters=0; buffer contents don't-care.
- States: IDLE, COLLECT, SEND, HOLD.
- IDLE:
  - Fixed-priority arbitration: lowest index with req_valid=1 wins.
  - Next cycle: state=COLLECT, owner=winner, owner_valid=1, wr_ptr=0, len=0.
- COLLECT:
  - req_ready[owner]=1; all other req_ready=0.
  - A byte is accepted when req_valid&req_ready.
  - While len<MAX_LEN, the byte is written to buf[len] and len increments.
  - Bytes beyond MAX_LEN are accepted and dropped (truncation); len saturates at MAX_LEN.
- COLLECT exits:
  - req_last accepted: SEND next cycle.
  - Idle counter reaches COLLECT_TIMEOUT-1 with no accepted byte: abort; go to IDLE; owner_valid and owner unchanged from before the grant; nothing sent.
  - The idle counter clears on every accepted byte.
- SEND:
  - ascii_data_ready=1 for exactly len consecutive cycles.
  - ascii_data=buf[k] on the k-th cycle, k=0..len-1; ready and data come from registered outputs and are aligned in the same cycle.
  - Buffer read latency is one cycle; the read pipeline is primed on SEND entry so there are no bubbles.
  - The first ascii_data_ready=1 occurs 2 cycles after the req_last acceptance edge.
  - After the last byte: ascii_data_ready=0, state=HOLD, hold counter=0.
- HOLD:
  - ascii_data_ready stays 0.
  - hold_cnt<GAP_CYCLES: no grants.
  - GAP_CYCLES<=hold_cnt<MIN_HOLD_CNT: only a requester with index<owner may win; it goes to COLLECT as from IDLE (preemption).
  - hold_cnt reaches MIN_HOLD_CNT-1: go to IDLE. owner_valid stays 1, because the text is still displayed.
- Simultaneous events: arbitration and hold expiry in the same cycle resolve to IDLE; arbitration happens the following cycle.
- Non-owners always see req_ready=0 and must hold their data.
- Widths: len and pointers are clog2(MAX_LEN+1) bits; hold and timeout counters are 25 bits and saturate at their terminal count.
- Scroller compatibility: every burst is 1..MAX_LEN long with at least GAP_CYCLES low cycles between bursts; a burst is never split.

Decomposition:
- Shared package (ui_pkg):
  - State encoding constants: IDLE=2'd0, COLLECT=2'd1, SEND=2'd2, HOLD=2'd3.
  - ASCII_SPACE=8'h20.
  - clog2 function.
- One sub-module: text_msg_buffer, a simple dual-port RAM of MAX_LEN x 8 with synchronous write and registered read, inferable as BRAM.

Test Plan:
- Basic send: req 2 sends "HELLO" (last on 'O').
  - req_ready[2]=1 one cycle after the valid edge.
  - After the last byte: ascii_data_ready high for exactly 5 contiguous cycles carrying 48,45,4C,4C,4F.
  - owner=2, owner_valid=1.
- Priority and hold:
  - req 1 and req 3 valid together in IDLE: req 1 wins.
  - During HOLD after req 1's message, req 3 valid: no grant until MIN_HOLD_CNT elapses (bench uses MIN_HOLD_CNT=100); then req 3 is granted.
- Preemption:
  - During HOLD of owner 2, req 0 asserts: granted at hold_cnt=GAP_CYCLES.
  - Its burst is separated from the prior burst by ≥2 low cycles.
- Truncation: MAX_LEN=16, 20-byte message.
  - All 20 bytes accepted.
  - Burst is 16 cycles of the first 16 bytes.
- Timeout:
  - Owner stalls after 3 bytes (COLLECT_TIMEOUT=50 in bench).
  - Return to IDLE after 50 cycles; ascii_data_ready never asserted; owner/owner_valid restored to prior values.
- Reset mid-SEND:
  - ascii_data_ready=0 and ascii_data=20 on the next edge.
  - owner_valid=0; a new request is served normally afterwards.

Source files
------------

// File: rtl/ui_pkg.sv
// Shared definitions for the LCD text path: FSM encoding, display constants
// and a constant-width helper for sizing pointers and counters.
package ui_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        SEND    = 2'd2,
        HOLD    = 2'd3
    } state_e;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam int         CNT_W       = 25;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) result++;
        return result;
    endfunction

endpackage

// File: rtl/text_msg_buffer.sv
// Simple dual-port message store: synchronous write, registered read,
// written so synthesis can map it onto a block RAM.
module text_msg_buffer
    import ui_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic [AW-1:0] rd_addr_i,
    output logic [7:0]    rd_data_o
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_data_q;

    // NOTE: the array has no reset; a reset term would stop it mapping to block RAM.
    always_ff @(posedge clk) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
        rd_data_q <= mem_q[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/text_msg_arbiter.sv
// Arbitrates message sources onto the LCD scroller: buffers one whole message,
// replays it as a single unbroken burst, then protects it for a minimum time.
module text_msg_arbiter
    import ui_pkg::*;
#(
    parameter int  NUM_REQ         = 4,
    parameter int  MAX_LEN         = 64,
    parameter int  MIN_HOLD_CNT    = 27000000,
    parameter int  GAP_CYCLES      = 2,
    parameter int  COLLECT_TIMEOUT = 1000000,
    localparam int OWN_W           = (NUM_REQ > 1) ? clog2(NUM_REQ) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [8*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic [7:0]           ascii_data,
    output logic                 ascii_data_ready,
    output logic [OWN_W-1:0]     owner,
    output logic                 owner_valid,
    output logic                 busy
);

    localparam int PTR_W  = clog2(MAX_LEN + 1);
    localparam int ADDR_W = clog2(MAX_LEN);

    localparam logic [PTR_W-1:0] LEN_MAX = PTR_W'(MAX_LEN);
    localparam logic [CNT_W-1:0] HOLD_TC = CNT_W'(MIN_HOLD_CNT - 1);
    localparam logic [CNT_W-1:0] GAP_TC  = CNT_W'(GAP_CYCLES);
    localparam logic [CNT_W-1:0] IDLE_TC = CNT_W'(COLLECT_TIMEOUT - 1);

    state_e             state_q;
    logic [NUM_REQ-1:0] req_ready_q;
    logic [7:0]         ascii_data_q;
    logic               ascii_ready_q;
    logic [OWN_W-1:0]   owner_q;
    logic               owner_valid_q;
    logic               busy_q;
    logic [OWN_W-1:0]   prev_owner_q;
    logic               prev_owner_valid_q;
    logic [PTR_W-1:0]   len_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic               rd_vld_q;
    logic [CNT_W-1:0]   idle_cnt_q;
    logic [CNT_W-1:0]   hold_cnt_q;

    logic               any_req;
    logic [OWN_W-1:0]   win_idx;
    logic               grant;
    logic               accept;
    logic               wr_en;
    logic [7:0]         owner_byte;
    logic [7:0]         rd_data;

    // NOTE: every output of an always_comb gets a default first, so no latch is inferred.
    always_comb begin
        any_req = 1'b0;
        win_idx = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                any_req = 1'b1;
                win_idx = OWN_W'(i);
            end
        end
    end

    // Preemption from HOLD needs a strictly higher-priority source and a finished gap.
    assign grant = any_req &&
                   ((state_q == IDLE) ||
                    (state_q == HOLD && hold_cnt_q >= GAP_TC &&
                     hold_cnt_q != HOLD_TC && win_idx < owner_q));

    assign accept     = (state_q == COLLECT) && |(req_valid & req_ready_q);
    assign owner_byte = req_data[8*int'(owner_q) +: 8];
    assign wr_en      = accept && (len_q < LEN_MAX);

    text_msg_buffer #(
        .DEPTH (MAX_LEN),
        .AW    (ADDR_W)
    ) u_buf (
        .clk       (clk),
        .wr_en_i   (wr_en),
        .wr_addr_i (len_q[ADDR_W-1:0]),
        .wr_data_i (owner_byte),
        .rd_addr_i (rd_ptr_q[ADDR_W-1:0]),
        .rd_data_o (rd_data)
    );

    // NOTE: sequential state uses <= only, so all registers see pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= IDLE;
            req_ready_q        <= '0;
            ascii_data_q       <= ASCII_SPACE;
            ascii_ready_q      <= 1'b0;
            owner_q            <= '0;
            owner_valid_q      <= 1'b0;
            busy_q             <= 1'b0;
            prev_owner_q       <= '0;
            prev_owner_valid_q <= 1'b0;
            len_q              <= '0;
            rd_ptr_q           <= '0;
            rd_vld_q           <= 1'b0;
            idle_cnt_q         <= '0;
            hold_cnt_q         <= '0;
        end else begin
            ascii_ready_q <= rd_vld_q;
            if (rd_vld_q) ascii_data_q <= rd_data;
            rd_vld_q <= 1'b0;

            if (grant) begin
                state_q            <= COLLECT;
                prev_owner_q       <= owner_q;
                prev_owner_valid_q <= owner_valid_q;
                owner_q            <= win_idx;
                owner_valid_q      <= 1'b1;
                req_ready_q        <= NUM_REQ'(1) << win_idx;
                len_q              <= '0;
                idle_cnt_q         <= '0;
                busy_q             <= 1'b1;
            end else begin
                case (state_q)
                    COLLECT: begin
                        if (accept) begin
                            idle_cnt_q <= '0;
                            if (len_q < LEN_MAX) len_q <= len_q + 1'b1;
                            if (req_last[owner_q]) begin
                                state_q     <= SEND;
                                req_ready_q <= '0;
                                rd_ptr_q    <= '0;
                            end
                        end else if (idle_cnt_q == IDLE_TC) begin
                            // Abandoned message: the previous text is still on screen.
                            state_q       <= IDLE;
                            req_ready_q   <= '0;
                            owner_q       <= prev_owner_q;
                            owner_valid_q <= prev_owner_valid_q;
                            busy_q        <= 1'b0;
                        end else begin
                            idle_cnt_q <= idle_cnt_q + 1'b1;
                        end
                    end
                    SEND: begin
                        if (rd_ptr_q < len_q) begin
                            rd_ptr_q <= rd_ptr_q + 1'b1;
                            rd_vld_q <= 1'b1;
                        end else if (!rd_vld_q) begin
                            state_q    <= HOLD;
                            hold_cnt_q <= '0;
                            busy_q     <= 1'b0;
                        end
                    end
                    HOLD: begin
                        if (hold_cnt_q == HOLD_TC) state_q <= IDLE;
                        else                       hold_cnt_q <= hold_cnt_q + 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign req_ready        = req_ready_q;
    assign ascii_data       = ascii_data_q;
    assign ascii_data_ready = ascii_ready_q;
    assign owner            = owner_q;
    assign owner_valid      = owner_valid_q;
    assign busy             = busy_q;

endmodule

// File: tb/tb_text_msg_arbiter.sv
// Self-checking bench for text_msg_arbiter: scoreboard of expected scroller
// bytes plus a message table and hand-written multi-cycle sequences.
module tb_text_msg_arbiter;

    localparam int NUM_REQ  = 4;
    localparam int MAX_LEN  = 16;
    localparam int MIN_HOLD = 100;
    localparam int GAP      = 2;
    localparam int TIMEOUT  = 50;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NUM_REQ-1:0]   req_valid;
    logic [8*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]   req_last;
    logic [NUM_REQ-1:0]   req_ready;
    logic [7:0]           ascii_data;
    logic                 ascii_data_ready;
    logic [1:0]           owner;
    logic                 owner_valid;
    logic                 busy;

    text_msg_arbiter #(
        .NUM_REQ         (NUM_REQ),
        .MAX_LEN         (MAX_LEN),
        .MIN_HOLD_CNT    (MIN_HOLD),
        .GAP_CYCLES      (GAP),
        .COLLECT_TIMEOUT (TIMEOUT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .req_valid        (req_valid),
        .req_data         (req_data),
        .req_last         (req_last),
        .req_ready        (req_ready),
        .ascii_data       (ascii_data),
        .ascii_data_ready (ascii_data_ready),
        .owner            (owner),
        .owner_valid      (owner_valid),
        .busy             (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         src;
        int         n;
        logic [7:0] base;
        int         exp_acc;
        int         exp_len;
    } vec_t;

    int         tests_run    = 0;
    int         tests_failed = 0;
    logic [7:0] exp_q[$];
    int         burst_count    = 0;
    int         last_burst_len = 0;
    int         cur_len        = 0;
    int         low_run        = 1000;
    logic       prev_rdy       = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [255:0] seq(input logic [7:0] base, input int n);
        logic [255:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[8*i +: 8] = base + 8'(i);
        return r;
    endfunction

    // Scroller-side monitor: pops the scoreboard and tracks burst framing.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            cur_len  = 0;
            low_run  = 1000;
            prev_rdy = 1'b0;
        end else begin
            if (ascii_data_ready) begin
                if (!prev_rdy) check("burst_gap_ge_2", 32'(low_run >= GAP), 32'd1);
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("FAIL unexpected_byte: got %0h expected no output", ascii_data);
                end else begin
                    check("burst_byte", 32'(ascii_data), 32'(exp_q.pop_front()));
                end
                cur_len++;
            end else begin
                if (prev_rdy) begin
                    last_burst_len = cur_len;
                    burst_count++;
                    cur_len = 0;
                    low_run = 0;
                end
                low_run++;
            end
            prev_rdy = ascii_data_ready;
        end
    end

    task automatic send_msg(input int src, input int n, input logic [255:0] p,
                            input bit do_last, input bit expect_out,
                            output int first_wait, output int accepted);
        int waited;
        first_wait = -1;
        accepted   = 0;
        for (int i = 0; i < n; i++) begin
            req_valid[src]         = 1'b1;
            req_data[8*src +: 8]   = p[8*i +: 8];
            req_last[src]          = do_last && (i == n - 1);
            waited = 0;
            @(negedge clk);
            while (!req_ready[src] && waited < 400) begin
                waited++;
                @(negedge clk);
            end
            if (!req_ready[src]) begin
                check($sformatf("send_stall_req%0d", src), 32'(req_ready[src]), 32'd1);
                req_valid[src] = 1'b0;
                req_last[src]  = 1'b0;
                return;
            end
            if (i == 0) first_wait = waited;
            @(posedge clk);
            #1;
            accepted++;
            if (expect_out && i < MAX_LEN) exp_q.push_back(p[8*i +: 8]);
        end
        req_valid[src] = 1'b0;
        req_last[src]  = 1'b0;
    endtask

    task automatic wait_burst_done(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || ascii_data_ready) && n < 300) begin
            n++;
            @(negedge clk);
        end
        check({name, "_drained"}, 32'(exp_q.size()), 32'd0);
        @(negedge clk);
    endtask

    task automatic wait_hold_over();
        repeat (MIN_HOLD + 20) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: run did not finish, time %0t expected under 500000", $time);
        $fatal(1);
    end

    initial begin
        vec_t         vecs[4];
        logic [255:0] p;
        logic [2:0]   lat;
        logic         rdy_seen;
        int           fw, acc, fw1, acc1, fw3, acc3, fw0, acc0, bc;

        vecs[0] = '{src: 3, n: 4,  base: 8'h30, exp_acc: 4,  exp_len: 4};
        vecs[1] = '{src: 1, n: 20, base: 8'h61, exp_acc: 20, exp_len: 16};
        vecs[2] = '{src: 0, n: 16, base: 8'h41, exp_acc: 16, exp_len: 16};
        vecs[3] = '{src: 2, n: 1,  base: 8'h7a, exp_acc: 1,  exp_len: 1};

        reset     = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_ascii_ready", 32'(ascii_data_ready), 32'd0);
        check("reset_ascii_data", 32'(ascii_data), 32'h20);
        check("reset_req_ready", 32'(req_ready), 32'd0);
        check("reset_owner", 32'(owner), 32'd0);
        check("reset_owner_valid", 32'(owner_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Basic send: "HELLO" from requester 2.
        p = '0;
        p[39:0] = 40'h4F4C4C4548;
        bc = burst_count;
        send_msg(2, 5, p, 1'b1, 1'b1, fw, acc);
        check("hello_ready_one_cycle_after_valid", 32'(fw), 32'd1);
        check("hello_accepted", 32'(acc), 32'd5);
        check("hello_busy_in_send", 32'(busy), 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            lat[k] = ascii_data_ready;
        end
        check("hello_first_ready_2_cycles_after_last", 32'(lat), 32'b100);
        wait_burst_done("hello");
        check("hello_burst_len", 32'(last_burst_len), 32'd5);
        check("hello_burst_count", 32'(burst_count), 32'(bc + 1));
        check("hello_owner", 32'(owner), 32'd2);
        check("hello_owner_valid", 32'(owner_valid), 32'd1);
        check("hello_busy_in_hold", 32'(busy), 32'd0);
        wait_hold_over();

        // Priority and hold: req 1 wins, req 3 waits out the whole hold window.
        bc = burst_count;
        fork
            send_msg(1, 3, seq(8'h31, 3), 1'b1, 1'b1, fw1, acc1);
            send_msg(3, 2, seq(8'h51, 2), 1'b1, 1'b1, fw3, acc3);
        join
        check("prio_req1_wins", 32'(fw1), 32'd1);
        // grant 1 + 3 bytes + 2 latency + 3 burst + MIN_HOLD hold + 1 arbitration
        check("prio_req3_waits_hold", 32'(fw3), 32'(MIN_HOLD + 10));
        wait_burst_done("prio");
        check("prio_burst_count", 32'(burst_count), 32'(bc + 2));
        check("prio_req3_len", 32'(last_burst_len), 32'd2);
        check("prio_owner", 32'(owner), 32'd3);
        wait_hold_over();

        // Table of plain messages, including the truncation and length boundaries.
        for (int v = 0; v < 4; v++) begin
            bc = burst_count;
            send_msg(vecs[v].src, vecs[v].n, seq(vecs[v].base, vecs[v].n), 1'b1, 1'b1, fw, acc);
            check($sformatf("vec%0d_accepted", v), 32'(acc), 32'(vecs[v].exp_acc));
            wait_burst_done($sformatf("vec%0d", v));
            check($sformatf("vec%0d_burst_len", v), 32'(last_burst_len), 32'(vecs[v].exp_len));
            check($sformatf("vec%0d_burst_count", v), 32'(burst_count), 32'(bc + 1));
            check($sformatf("vec%0d_owner", v), 32'(owner), 32'(vecs[v].src));
            check($sformatf("vec%0d_owner_valid", v), 32'(owner_valid), 32'd1);
            wait_hold_over();
        end

        // Preemption: req 0 arrives at the start of owner 2's hold.
        bc = burst_count;
        send_msg(2, 4, seq(8'h61, 4), 1'b1, 1'b1, fw, acc);
        repeat (4 + 3) @(negedge clk);
        check("preempt_in_hold", 32'(ascii_data_ready), 32'd0);
        send_msg(0, 2, seq(8'h21, 2), 1'b1, 1'b1, fw0, acc0);
        check("preempt_granted_at_gap", 32'(fw0), 32'(GAP));
        wait_burst_done("preempt");
        check("preempt_burst_count", 32'(burst_count), 32'(bc + 2));
        check("preempt_len", 32'(last_burst_len), 32'd2);
        check("preempt_owner", 32'(owner), 32'd0);
        wait_hold_over();

        // Timeout: req 3 stalls after three bytes; prior owner 0 must come back.
        bc = burst_count;
        rdy_seen = 1'b0;
        send_msg(3, 3, seq(8'h70, 3), 1'b0, 1'b0, fw, acc);
        check("timeout_owner_during_collect", 32'(owner), 32'd3);
        repeat (TIMEOUT) begin
            @(negedge clk);
            rdy_seen = rdy_seen | ascii_data_ready;
        end
        check("timeout_busy_before_expiry", 32'(busy), 32'd1);
        @(negedge clk);
        check("timeout_busy_after_expiry", 32'(busy), 32'd0);
        check("timeout_req_ready_dropped", 32'(req_ready), 32'd0);
        check("timeout_no_output", 32'(rdy_seen | ascii_data_ready), 32'd0);
        check("timeout_no_burst", 32'(burst_count), 32'(bc));
        check("timeout_owner_restored", 32'(owner), 32'd0);
        check("timeout_owner_valid_restored", 32'(owner_valid), 32'd1);

        // Reset in the middle of a burst, then normal service again.
        send_msg(2, 10, seq(8'h41, 10), 1'b1, 1'b1, fw, acc);
        repeat (4) @(negedge clk);
        check("midsend_burst_active", 32'(ascii_data_ready), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("midsend_reset_ready", 32'(ascii_data_ready), 32'd0);
        check("midsend_reset_data", 32'(ascii_data), 32'h20);
        check("midsend_reset_owner_valid", 32'(owner_valid), 32'd0);
        check("midsend_reset_busy", 32'(busy), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        bc = burst_count;
        send_msg(1, 3, seq(8'h58, 3), 1'b1, 1'b1, fw, acc);
        check("post_reset_grant", 32'(fw), 32'd1);
        wait_burst_done("post_reset");
        check("post_reset_len", 32'(last_burst_len), 32'd3);
        check("post_reset_burst_count", 32'(burst_count), 32'(bc + 1));
        check("post_reset_owner", 32'(owner), 32'd1);
        check("post_reset_owner_valid", 32'(owner_valid), 32'd1);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
